// File: rtl/btn_pkg.sv
// Shared constants for the button/switch conditioner: channel counts, button
// indices and the status_word field layout seen by IO_Interface.
package btn_pkg;
  localparam int NUM_BTN          = 4;
  localparam int NUM_SW           = 2;
  localparam int DEBOUNCE_DEFAULT = 20000;
  localparam int CNT_W            = 16;

  localparam int BTN_RIGHT   = 0;
  localparam int BTN_START   = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RESTART = 3;

  localparam int ST_LVL_LSB = 0;
  localparam int ST_EVT_LSB = 4;
  localparam int ST_SW_LSB  = 8;
endpackage

// File: rtl/debounce_cell.sv
// One input channel: two-flop synchronizer, hold counter and stable register.
// rise is combinational and high on the cycle before level goes 0->1.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0, sync1;
  logic [CNT_W-1:0] cnt;

  // Accept on the edge that ends the DEBOUNCE_CYCLES-th mismatching cycle.
  assign rise = (sync1 != level) && (cnt == LIMIT) && sync1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == LIMIT) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// Debounces the pushbuttons and slide switches and keeps sticky press flags
// that the CPU clears by reading the button port.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_DEFAULT,
  parameter int NUM_BTN         = btn_pkg::NUM_BTN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [1:0]         sw_raw,
  input  logic               evt_clr,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_event,
  output logic [1:0]         sw_level,
  output logic [31:0]        status_word
);
  import btn_pkg::*;

  localparam int NCH = NUM_BTN + 2;

  logic [NCH-1:0] raw_all, lvl_all, rise_all;
  logic [1:0]     sw_rise_unused;

  assign raw_all = {sw_raw, btn_raw};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_all[i]),
      .level (lvl_all[i]),
      .rise  (rise_all[i])
    );
  end

  assign btn_level      = lvl_all[NUM_BTN-1:0];
  assign sw_level       = lvl_all[NCH-1:NUM_BTN];
  assign sw_rise_unused = rise_all[NCH-1:NUM_BTN];

  // A press arriving with evt_clr survives the clear.
  always_ff @(posedge clk) begin
    if (reset) btn_event <= '0;
    else       btn_event <= (btn_event & {NUM_BTN{~evt_clr}}) | rise_all[NUM_BTN-1:0];
  end

  always_comb begin
    status_word                           = '0;
    status_word[ST_LVL_LSB +: NUM_BTN]    = btn_level;
    status_word[ST_EVT_LSB +: NUM_BTN]    = btn_event;
    status_word[ST_SW_LSB  +: NUM_SW]     = sw_level;
  end
endmodule
